// File: rtl/ether_pkg.sv
// Shared RMII receive types and framing constants, also used by the
// downstream dibit-reorder and checksum stages.
package ether_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        DROP     = 2'd3
    } ether_rx_state_t;

    localparam logic [1:0] PRE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT = 2'b11;

endpackage

// File: rtl/ether_rx.sv
// RMII receive front end: checks preamble/SFD, strips it and streams the
// payload dibits (FCS included) one cycle after sampling, with framing flags.
module ether_rx
    import ether_pkg::*;
#(
    parameter int MIN_PRE_DIBITS   = 28,
    parameter int MAX_FRAME_DIBITS = 6104,
    parameter int CNT_W            = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       crsdv,
    input  logic [1:0] rxd,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       sof,
    output logic       eof,
    output logic       odd_len,
    output logic       bad_pre,
    output logic       too_long
);

    localparam logic [CNT_W-1:0] MIN_PRE = CNT_W'(MIN_PRE_DIBITS);
    localparam logic [CNT_W-1:0] MAX_PAY = CNT_W'(MAX_FRAME_DIBITS);

    ether_rx_state_t  state_q, state_d;
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
    logic             axiov_q, axiov_d;
    logic [1:0]       axiod_q, axiod_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             odd_len_q, odd_len_d;
    logic             bad_pre_q, bad_pre_d;
    logic             too_long_q, too_long_d;

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        pay_cnt_d  = pay_cnt_q;
        axiov_d    = 1'b0;
        axiod_d    = 2'b00;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        odd_len_d  = 1'b0;
        bad_pre_d  = 1'b0;
        too_long_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (crsdv) begin
                    if (rxd == PRE_DIBIT) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = CNT_W'(1);
                    end else begin
                        state_d   = DROP;
                        bad_pre_d = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!crsdv) begin
                    state_d   = IDLE;
                    bad_pre_d = 1'b1;
                end else if (rxd == PRE_DIBIT) begin
                    if (pre_cnt_q != '1) begin
                        pre_cnt_d = pre_cnt_q + CNT_W'(1);
                    end
                end else if (rxd == SFD_DIBIT && pre_cnt_q >= MIN_PRE) begin
                    state_d   = PAYLOAD;
                    pay_cnt_d = '0;
                end else begin
                    state_d   = DROP;
                    bad_pre_d = 1'b1;
                end
            end
            PAYLOAD: begin
                if (!crsdv) begin
                    state_d   = IDLE;
                    eof_d     = 1'b1;
                    odd_len_d = (pay_cnt_q[1:0] != 2'b00);
                end else if (pay_cnt_q >= MAX_PAY) begin
                    // Overlong frame is cut without eof so downstream discards it.
                    state_d    = DROP;
                    too_long_d = 1'b1;
                end else begin
                    axiov_d   = 1'b1;
                    axiod_d   = rxd;
                    sof_d     = (pay_cnt_q == '0);
                    pay_cnt_d = pay_cnt_q + CNT_W'(1);
                end
            end
            DROP: begin
                if (!crsdv) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = DROP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= DROP;
            pre_cnt_q  <= '0;
            pay_cnt_q  <= '0;
            axiov_q    <= 1'b0;
            axiod_q    <= 2'b00;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            odd_len_q  <= 1'b0;
            bad_pre_q  <= 1'b0;
            too_long_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            axiov_q    <= axiov_d;
            axiod_q    <= axiod_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            odd_len_q  <= odd_len_d;
            bad_pre_q  <= bad_pre_d;
            too_long_q <= too_long_d;
        end
    end

    assign axiov    = axiov_q;
    assign axiod    = axiod_q;
    assign sof      = sof_q;
    assign eof      = eof_q;
    assign odd_len  = odd_len_q;
    assign bad_pre  = bad_pre_q;
    assign too_long = too_long_q;

endmodule
